// File: rtl/tlc_phase_sequencer.sv
// Timing and sensor front end for the highway/farm-way traffic light FSM.
// Optional farm-green ceiling enabled by defining TLC_SEQ_FG_MAXGREEN_EN.
module tlc_phase_sequencer #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 20,
  parameter int YELLOW_T  = 4,
  parameter int GREEN_MAX = 60
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic             car_raw,
  input  logic [1:0]       hwy,
  input  logic [1:0]       fwy,
  output logic             en,
  output logic             x,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             err
);

  localparam int GMIN_I = (GREEN_MIN == 0) ? 1 : GREEN_MIN;
  localparam int YEL_I  = (YELLOW_T == 0) ? 1 : YELLOW_T;
  localparam int GMAX_I = (GREEN_MAX == 0) ? 1 : GREEN_MAX;
  localparam logic [CNT_W-1:0] GMIN_C = GMIN_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] YEL_C  = YEL_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] GMAX_C = GMAX_I[CNT_W-1:0];
`ifdef TLC_SEQ_FG_MAXGREEN_EN
  localparam logic GMAX_EN = 1'b1;
`else
  localparam logic GMAX_EN = 1'b0;
`endif

  typedef enum logic [2:0] {PH_HG, PH_HY, PH_FG, PH_FY, PH_ILL} phase_e;
  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             sync1_q, sync2_q;
  logic             req_q, req_d;
  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  phase_e           phase;
  logic             chk_q, chk_d;
  logic             en_q, en_d;
  logic             x_q, x_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic             car_s, expire;

  assign car_s = sync2_q;

  always_comb begin
    case ({hwy, fwy})
      4'b1001: phase = PH_HG;
      4'b0001: phase = PH_HY;
      4'b0110: phase = PH_FG;
      4'b0100: phase = PH_FY;
      default: phase = PH_ILL;
    endcase
  end

  always_comb begin
    cnt_n  = sat_inc(cnt_q);
    expire = 1'b0;
    case (phase)
      PH_HG:        expire = (cnt_n >= GMIN_C) && req_q;
      PH_HY, PH_FY: expire = (cnt_n >= YEL_C);
      PH_FG:        expire = ((cnt_n >= GMIN_C) && !car_s) || (GMAX_EN && (cnt_n >= GMAX_C));
      default:      expire = 1'b0;
    endcase
  end

  // The FSM only shows its new phase the cycle after WAIT, so the
  // did-it-advance check is deferred to that cycle via chk_q.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    chk_d   = 1'b0;
    en_d    = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          if (expire) begin
            en_d    = 1'b1;
            cnt_d   = '0;
            phase_d = phase;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_n;
          end
        end
      end
      ST_WAIT: begin
        state_d = ST_RUN;
        chk_d   = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (chk_q && (phase == phase_q)) err_d = 1'b1;
    if (phase == PH_ILL) err_d = 1'b1;
  end

  always_comb begin
    req_d = (phase == PH_FG) ? 1'b0 : (req_q | car_s);
    case (phase)
      PH_HG, PH_HY: x_d = req_q;
      PH_FG:        x_d = !en_d;
      default:      x_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      req_q   <= 1'b0;
      state_q <= ST_RUN;
      phase_q <= PH_HG;
      chk_q   <= 1'b0;
      en_q    <= 1'b0;
      x_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= car_raw;
      sync2_q <= sync1_q;
      req_q   <= req_d;
      state_q <= state_d;
      phase_q <= phase_d;
      chk_q   <= chk_d;
      en_q    <= en_d;
      x_q     <= x_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en        = en_q;
  assign x         = x_q;
  assign phase_cnt = cnt_q;
  assign err       = err_q;

endmodule
